mult_bcd_window: RTL

MULT_BCD_WINDOW -- requirements
Module: mult_bcd_window

---
 rtl/mult_bcd_window_pkg.sv | 22 ++
 rtl/mult_bcd_window_if.sv | 34 +++
 rtl/mult_bcd_window_conv.sv | 50 +++++
 rtl/mult_bcd_window.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_bcd_window_pkg.sv
// Shared types and constants for the signed multiplier with a BCD window display.
package mult_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_CONV,
        ST_DONE
    } state_e;

    // Nibble shown in place of a leading zero when blanking is enabled.
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/mult_bcd_window_if.sv
// Request/result bundle between a requester (master) and the multiplier (slave).
interface mult_bcd_window_if #(
    parameter int W      = 8,
    parameter int DIGITS = 5,
    parameter int WIN    = 3
);
    import mult_bcd_pkg::*;

    // Offset is at least one bit wide even when the window covers every digit.
    localparam int OFF_W = (clog2(DIGITS - WIN + 1) > 0) ? clog2(DIGITS - WIN + 1) : 1;

    logic               start;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic               shift_left;
    logic               shift_right;
    logic               busy;
    logic               done;
    logic               negative;
    logic [2*W-1:0]     magnitude;
    logic [4*WIN-1:0]   window;
    logic [OFF_W-1:0]   offset;

    modport master (
        output start, a, b, shift_left, shift_right,
        input  busy, done, negative, magnitude, window, offset
    );

    modport slave (
        input  start, a, b, shift_left, shift_right,
        output busy, done, negative, magnitude, window, offset
    );

endinterface

// File: rtl/mult_bcd_window_conv.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// load_i performs the first shift directly: with an all-zero BCD register the
// add-3 correction can never fire, so loading and shifting in one cycle is exact.
// A full conversion is therefore load_i once followed by BW-1 step_i cycles.
module bcd_seq_converter #(
    parameter int BW     = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [BW-1:0]         bin_i,
    input  logic                  step_i,
    output logic [4*DIGITS-1:0]   bcd_o
);

    logic [BW-1:0]       bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;

    // Add-3 correction per digit, then shift the binary MSB into the BCD LSB.
    always_comb begin
        adj   = bcd_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        if (load_i) begin
            bcd_d = {{(4*DIGITS-1){1'b0}}, bin_i[BW-1]};
            bin_d = {bin_i[BW-2:0], 1'b0};
        end else if (step_i) begin
            bcd_d = {adj[4*DIGITS-2:0], bin_q[BW-1]};
            bin_d = {bin_q[BW-2:0], 1'b0};
        end
    end

    // Working registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/mult_bcd_window.sv
// Signed shift-add multiplier with BCD conversion and a movable digit window.
// Optional feature: define MULT_BCD_LEADING_BLANK_EN to show digits above the
// most significant nonzero digit as BLANK_DIGIT.
module mult_bcd_window
    import mult_bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 5,
    parameter int WIN    = 3
) (
    input  logic               clk,
    input  logic               rst,
    mult_bcd_window_if.slave   bus
);

    localparam int OFF_W = (clog2(DIGITS - WIN + 1) > 0) ? clog2(DIGITS - WIN + 1) : 1;
    localparam int CW    = clog2(2 * W) + 1;
    localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(DIGITS - WIN);

    logic [1:0]          rst_sync_q;
    logic                rst_n;
    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*W-1:0]      mcand_q, mcand_d, prod_q, prod_d;
    logic [W-1:0]        mplier_q, mplier_d;
    logic                sign_q, sign_d;
    logic [W-1:0]        abs_a, abs_b;
    logic [2*W-1:0]      mag_q;
    logic                neg_q;
    logic [4*DIGITS-1:0] bcd_q, conv_bcd;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [4*WIN-1:0]    win;
    logic                conv_load, conv_step, finish;
    int                  idx;
    logic [3:0]          nib;
`ifdef MULT_BCD_LEADING_BLANK_EN
    int                  msd;
`endif

    // Reset asserts immediately but releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Magnitudes in W unsigned bits: the most negative value maps to 2^(W-1).
    assign abs_a = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
    assign abs_b = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;

    // Next state and phase counter: W multiply cycles, 2W conversion cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_MULT;
            ST_MULT: if (cnt_q == CW'(W - 1)) state_d = ST_CONV;
            ST_CONV: if (cnt_q == CW'(2 * W - 1)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d = ((state_d == state_q) && (state_q == ST_MULT || state_q == ST_CONV))
                ? cnt_q + CW'(1) : '0;
    end

    // Operand capture on acceptance, then one shift-add step per MULT cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        if (state_q == ST_IDLE && bus.start) begin
            mcand_d  = {{W{1'b0}}, abs_a};
            mplier_d = abs_b;
            prod_d   = '0;
            sign_d   = bus.a[W-1] ^ bus.b[W-1];
        end else if (state_q == ST_MULT) begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[W-1:1]};
        end
    end

    // The converter is loaded with the final product on the last MULT edge and
    // stepped through all but the last CONV cycle, which hands the result over.
    assign conv_load = (state_q == ST_MULT) && (cnt_q == CW'(W - 1));
    assign conv_step = (state_q == ST_CONV) && (cnt_q != CW'(2 * W - 1));
    assign finish    = (state_q == ST_CONV) && (state_d == ST_DONE);

    bcd_seq_converter #(.BW(2 * W), .DIGITS(DIGITS)) u_conv (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (conv_load),
        .bin_i  (prod_d),
        .step_i (conv_step),
        .bcd_o  (conv_bcd)
    );

    // Window position: shifts only while idle, simultaneous pulses cancel.
    always_comb begin
        off_d = off_q;
        if (state_q == ST_DONE) begin
            off_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (bus.shift_left && !bus.shift_right && off_q != MAX_OFF)
                off_d = off_q + OFF_W'(1);
            else if (bus.shift_right && !bus.shift_left && off_q != '0)
                off_d = off_q - OFF_W'(1);
        end
    end

    // FSM, datapath and window position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            off_q    <= off_d;
        end
    end

    // Visible results change only as DONE is entered and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            neg_q <= 1'b0;
            bcd_q <= '0;
        end else if (finish) begin
            mag_q <= prod_q;
            neg_q <= sign_q && (prod_q != '0);
            bcd_q <= conv_bcd;
        end
    end

    // Window digits [offset+WIN-1 : offset], optionally blanking leading zeros.
    always_comb begin
        win = '0;
        idx = 0;
        nib = '0;
`ifdef MULT_BCD_LEADING_BLANK_EN
        msd = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) msd = k;
        end
`endif
        for (int i = 0; i < WIN; i++) begin
            idx = int'(off_q) + i;
            nib = bcd_q[4*idx +: 4];
`ifdef MULT_BCD_LEADING_BLANK_EN
            if (idx > msd) nib = BLANK_DIGIT;
`endif
            win[4*i +: 4] = nib;
        end
    end

    assign bus.busy      = (state_q == ST_MULT) || (state_q == ST_CONV);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.negative  = neg_q;
    assign bus.magnitude = mag_q;
    assign bus.window    = win;
    assign bus.offset    = off_q;

endmodule
